// File: rtl/range_avg_pkg.sv
// Shared constants and state type for the ultrasonic range averager.
package range_avg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  localparam int unsigned MIN_LEN_DEF = 116;    // 2 cm
  localparam int unsigned MAX_LEN_DEF = 23200;  // 4 m
  localparam int unsigned US_PER_CM   = 58;

endpackage

// File: rtl/range_avg_rise.sv
// Rising-edge detector; the previous-value register resets to RST_VAL.
module rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk50M,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) prev <= RST_VAL;
    else     prev <= sig;
  end

  assign pulse = sig & ~prev;

endmodule

// File: rtl/range_avg.sv
// Averages 2^AVG_LOG2 in-range echo lengths; aborts with err after MAX_REJ consecutive rejects.
module range_avg
  import range_avg_pkg::*;
#(
  parameter int unsigned CAP_LEN  = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned MIN_LEN  = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
  parameter int unsigned MAX_REJ  = 3
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic               en,
  input  logic               done_in,
  input  logic [CAP_LEN-1:0] len_in,
  output logic               trig_en,
  output logic [CAP_LEN-1:0] avg_len,
  output logic               valid,
  output logic               err
);

  localparam int unsigned ACC_W = CAP_LEN + AVG_LOG2;
  localparam int unsigned GC_W  = AVG_LOG2 + 1;
  localparam int unsigned RC_W  = (MAX_REJ < 1) ? 1 : $clog2(MAX_REJ + 1);

  localparam logic [CAP_LEN-1:0] LEN_LO  = CAP_LEN'(MIN_LEN);
  localparam logic [CAP_LEN-1:0] LEN_HI  = CAP_LEN'(MAX_LEN);
  localparam logic [GC_W-1:0]    N_SAMP  = GC_W'(1 << AVG_LOG2);
  localparam logic [GC_W-1:0]    GC_ONE  = GC_W'(1);
  localparam logic [RC_W-1:0]    REJ_LIM = RC_W'(MAX_REJ);
  localparam logic [RC_W-1:0]    RC_ONE  = RC_W'(1);

  state_t             state, state_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [GC_W-1:0]    good_cnt, good_d;
  logic [RC_W-1:0]    rej_cnt, rej_d;
  logic [CAP_LEN-1:0] avg_d;
  logic               err_d, valid_d, trig_d;
  logic               sample;
  logic               in_range;

  rise_det #(.RST_VAL(1'b1)) u_rise (
    .clk50M (clk50M),
    .rst    (rst),
    .sig    (done_in),
    .pulse  (sample)
  );

  assign in_range = (len_in >= LEN_LO) && (len_in <= LEN_HI);

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      good_cnt <= '0;
      rej_cnt  <= '0;
      avg_len  <= '0;
      err      <= 1'b0;
      valid    <= 1'b0;
      trig_en  <= 1'b0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      good_cnt <= good_d;
      rej_cnt  <= rej_d;
      avg_len  <= avg_d;
      err      <= err_d;
      valid    <= valid_d;
      trig_en  <= trig_d;
    end
  end

  // Completion is tested on the registered counts, so the result appears the
  // cycle after the finishing sample; dropping en takes priority and discards.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    good_d  = good_cnt;
    rej_d   = rej_cnt;
    avg_d   = avg_len;
    err_d   = err;
    valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_d = COLLECT;
          acc_d   = '0;
          good_d  = '0;
          rej_d   = '0;
        end
      end
      COLLECT: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          good_d  = '0;
          rej_d   = '0;
        end else if (good_cnt == N_SAMP) begin
          state_d = EMIT;
          valid_d = 1'b1;
          err_d   = 1'b0;
          avg_d   = acc[ACC_W-1:AVG_LOG2];
        end else if (rej_cnt == REJ_LIM) begin
          state_d = EMIT;
          valid_d = 1'b1;
          err_d   = 1'b1;
          avg_d   = '1;
        end else if (sample) begin
          if (in_range) begin
            acc_d  = acc + ACC_W'(len_in);
            good_d = good_cnt + GC_ONE;
            rej_d  = '0;
          end else begin
            rej_d  = rej_cnt + RC_ONE;
          end
        end
      end
      EMIT: begin
        state_d = en ? COLLECT : IDLE;
        acc_d   = '0;
        good_d  = '0;
        rej_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    trig_d = (state_d == COLLECT);
  end

endmodule

// File: tb/tb_range_avg.sv
// Randomized scoreboard bench for range_avg against a sample-list reference model.
module tb_range_avg;

  logic        clk50M = 1'b0;
  logic        rst;
  logic        en;
  logic        done_in;
  logic [15:0] len_in;
  logic        trig_en;
  logic [15:0] avg_len;
  logic        valid;
  logic        err;

  typedef struct {
    logic        err;
    logic [15:0] avg;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  int unsigned m_good[$];
  int          m_rej;

  range_avg #(
    .CAP_LEN  (16),
    .AVG_LOG2 (2),
    .MIN_LEN  (116),
    .MAX_LEN  (23200),
    .MAX_REJ  (3)
  ) dut (
    .clk50M  (clk50M),
    .rst     (rst),
    .en      (en),
    .done_in (done_in),
    .len_in  (len_in),
    .trig_en (trig_en),
    .avg_len (avg_len),
    .valid   (valid),
    .err     (err)
  );

  always #10 clk50M = ~clk50M;

  always @(posedge clk50M) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk50M) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 err=%0d avg=%0d expected no result (cycle %0d)",
                 err, avg_len, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_err", {31'd0, err}, {31'd0, e.err});
        chk("result_avg", {16'd0, avg_len}, {16'd0, e.avg});
        chk("result_latency", cyc, e.cyc);
      end
    end
  end

  function automatic void model_clear();
    m_good.delete();
    m_rej = 0;
  endfunction

  // Reference: collect accepted lengths in a list, average when four are held.
  function automatic void model_sample(input int unsigned len, input int drive_cyc);
    exp_t e;
    int unsigned sum;
    if (len >= 116 && len <= 23200) begin
      m_good.push_back(len);
      m_rej = 0;
    end else begin
      m_rej++;
    end
    if (m_good.size() == 4) begin
      sum = 0;
      foreach (m_good[i]) sum += m_good[i];
      e.err = 1'b0;
      e.avg = 16'(sum / 4);
      e.cyc = drive_cyc + 2;
      sb.push_back(e);
      model_clear();
    end else if (m_rej == 3) begin
      e.err = 1'b1;
      e.avg = 16'hFFFF;
      e.cyc = drive_cyc + 2;
      sb.push_back(e);
      model_clear();
    end
  endfunction

  task automatic send(input logic [15:0] len, input int hi, input int lo);
    @(posedge clk50M); #1;
    done_in = 1'b1;
    len_in  = len;
    model_sample(len, cyc);
    repeat (hi) @(posedge clk50M);
    #1 done_in = 1'b0;
    repeat (lo - 1) @(posedge clk50M);
  endtask

  task automatic send_std(input logic [15:0] len);
    send(len, 2, 2);
  endtask

  initial begin
    logic [15:0] len;
    int          pick;

    rst = 1'b1; en = 1'b0; done_in = 1'b1; len_in = '0;
    model_clear();
    #3;
    chk("reset_trig_en", {31'd0, trig_en}, 32'd0);
    chk("reset_valid",   {31'd0, valid},   32'd0);
    chk("reset_err",     {31'd0, err},     32'd0);
    chk("reset_avg",     {16'd0, avg_len}, 32'd0);

    // done_in already high at release must not count as a sample
    repeat (3) @(posedge clk50M);
    #1 rst = 1'b0; en = 1'b1; len_in = 16'd1000;
    @(posedge clk50M); #1;
    chk("collect_trig_en", {31'd0, trig_en}, 32'd1);
    repeat (100) @(posedge clk50M);
    #1 done_in = 1'b0;

    send_std(16'd580); send_std(16'd590); send_std(16'd600); send_std(16'd610);
    send_std(16'd100); send_std(16'd30000); send_std(16'd23201);
    send_std(16'd116); send_std(16'd23200); send_std(16'd50);
    send_std(16'd1000); send_std(16'd1000);

    // partial accumulation then en drop, with a coincident done_in edge
    send_std(16'd400); send_std(16'd400);
    @(posedge clk50M); #1;
    chk("trig_before_drop", {31'd0, trig_en}, 32'd1);
    en = 1'b0; done_in = 1'b1; len_in = 16'd400;
    model_clear();
    @(posedge clk50M); #1;
    chk("trig_after_drop", {31'd0, trig_en}, 32'd0);
    done_in = 1'b0;
    repeat (5) @(posedge clk50M);
    #1;
    chk("idle_trig_en", {31'd0, trig_en}, 32'd0);
    en = 1'b1;
    repeat (4) send_std(16'd400);

    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        6:       len = 16'($urandom_range(0, 115));
        7:       len = 16'($urandom_range(23201, 65535));
        8:       len = ($urandom_range(0, 1) != 0) ? 16'd116 : 16'd23200;
        9:       len = ($urandom_range(0, 1) != 0) ? 16'd115 : 16'd23201;
        default: len = 16'($urandom_range(116, 23200));
      endcase
      send(len, $urandom_range(1, 3), $urandom_range(2, 4));
    end

    // asynchronous reset in the middle of a collection
    send_std(16'd2000); send_std(16'd3000);
    @(posedge clk50M); #5;
    rst = 1'b1; done_in = 1'b1;
    #1;
    chk("midrst_trig_en", {31'd0, trig_en}, 32'd0);
    chk("midrst_valid",   {31'd0, valid},   32'd0);
    chk("midrst_err",     {31'd0, err},     32'd0);
    chk("midrst_avg",     {16'd0, avg_len}, 32'd0);
    model_clear();
    repeat (2) @(posedge clk50M);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk50M);
    #1 done_in = 1'b0;
    send_std(16'd800); send_std(16'd900); send_std(16'd1000); send_std(16'd1101);

    repeat (4) @(posedge clk50M);
    #1 en = 1'b0;
    repeat (10) @(posedge clk50M);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/range_avg.md
RANGE_AVG -- requirements
Module: range_avg

Interface
REQ-001 SHALL have parameter CAP_LEN, default 16, width of echo length and average, in us.
REQ-002 SHALL have parameter AVG_LOG2, default 2, log2 of the number of samples averaged per result (N = 4).
REQ-003 SHALL have parameter MIN_LEN, default 116, minimum valid echo length (2 cm).
REQ-004 SHALL have parameter MAX_LEN, default 23200, maximum valid echo length (4 m).
REQ-005 SHALL have parameter MAX_REJ, default 3, consecutive rejected samples that abort the average.
REQ-006 clk50M  input  1  sole clock, 50 MHz; one clock; all state on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 en  input  1  run request from the scan controller.
REQ-009 done_in  input  1  level done from the HC-SR04 driver; a rising edge means len_in holds a new result.
REQ-010 len_in  input  CAP_LEN  echo length from the driver, stable while done_in is high.
REQ-011 trig_en  output  1  measurement request to the driver's en.
REQ-012 avg_len  output  CAP_LEN  averaged length, held until the next result.
REQ-013 valid  output  1  one-cycle pulse when avg_len/err update.
REQ-014 err  output  1  qualifies the result; 1 = abort, with avg_len forced to all-ones.

Function
REQ-015 SHALL implement states IDLE, COLLECT and EMIT.
REQ-016 In IDLE, trig_en SHALL be 0; en=1 moves to COLLECT next cycle with the accumulator and counters cleared.
REQ-017 In COLLECT, trig_en SHALL be 1 (registered output).
REQ-018 A new sample SHALL be a done_in rising edge (prev=0, now=1); len_in is captured in the same cycle the edge is detected.
REQ-019 Sample with MIN_LEN <= len_in <= MAX_LEN (inclusive) SHALL add to the accumulator, increment good_cnt and clear rej_cnt.
REQ-020 Out-of-range sample SHALL increment rej_cnt and leave the accumulator and good_cnt unchanged.
REQ-021 The accumulator SHALL be CAP_LEN+AVG_LOG2 bits wide; overflow is impossible by construction.
REQ-022 When good_cnt reaches 2^AVG_LOG2, the block SHALL go to EMIT on the cycle after the last accepted sample.
  - avg_len = acc >> AVG_LOG2 (truncating).
  - err = 0.
REQ-023 When rej_cnt reaches MAX_REJ, the block SHALL go to EMIT.
  - avg_len = all-ones.
  - err = 1.
REQ-024 EMIT SHALL last exactly one cycle with valid=1, then go to COLLECT (counters cleared) if en=1, else IDLE.
REQ-025 Latency SHALL be exactly 2 clk50M cycles from the done_in edge of the completing sample to valid=1.
REQ-026 en=0 in COLLECT SHALL drop trig_en next cycle, discard the partial accumulation and return to IDLE with no valid pulse.
REQ-027 A done_in edge coincident with en falling SHALL be discarded.
REQ-028 done_in edges in IDLE or EMIT SHALL be ignored.
REQ-029 done_in held high SHALL count once; only edges count.
REQ-030 err and avg_len SHALL change only in the cycle valid is asserted.

Reset
REQ-031 On rst: state=IDLE, trig_en=0, valid=0, err=0, avg_len=0, acc=0, good_cnt=0, rej_cnt=0.
REQ-032 The done_in edge-detect register SHALL reset to 1, so a driver that is high after reset produces no false sample.
REQ-033 rst mid-COLLECT SHALL abort immediately with no valid pulse; the first sample after release requires a fresh done_in low-to-high.

Structure
REQ-034 State encodings, MIN_LEN/MAX_LEN defaults and the us-per-cm constant (58) SHALL live in the shared project include/package.
REQ-035 The done_in rising-edge detector SHALL be one sub-module, rise_det (clk50M, rst, sig, pulse), with reset value parameterised.

Verification
REQ-036 en=1; four samples 580,590,600,610 -> valid pulse, err=0, avg_len=595, 2 cycles after the 4th edge.
REQ-037 en=1; samples 100, 30000, 23201 -> valid, err=1, avg_len=16'hFFFF; no further accumulation from these.
REQ-038 samples 116, 23200, 50, 1000, 1000 -> 50 rejected, rej_cnt cleared by 1000; avg_len=(116+23200+1000+1000)>>2=6329, err=0.
REQ-039 two samples accepted, then en=0 -> trig_en=0 next cycle, no valid; re-enable and four samples of 400 -> avg_len=400.
REQ-040 done_in=1 from reset release, held 100 cycles -> no sample counted; rst asserted mid-COLLECT -> all outputs at reset values asynchronously.
